// File: rtl/wb_stage.sv
// Writeback stage: one-entry pipeline register feeding the register file.
// Also provides load extraction, a forwarding tap, retire counting and ebreak halt.
module wb_stage #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_pc,
  input  logic [ADDR_WIDTH-1:0] in_rd,
  input  logic                  in_wen,
  input  logic                  in_is_load,
  input  logic [2:0]            in_funct3,
  input  logic [DATA_WIDTH-1:0] in_alu_result,
  input  logic [DATA_WIDTH-1:0] in_mem_rdata,
  input  logic                  in_is_ebreak,
  input  logic                  stall,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_rd,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic                  fwd_valid,
  output logic [ADDR_WIDTH-1:0] fwd_rd,
  output logic [DATA_WIDTH-1:0] fwd_data,
  output logic                  commit,
  output logic [DATA_WIDTH-1:0] commit_pc,
  output logic [63:0]           instret,
  output logic                  halted
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  typedef struct packed {
    logic                  valid;
    logic                  ebreak;
    logic                  wen;
    logic [ADDR_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] data;
  } wb_q_t;

  state_t state_q;
  state_t state_d;
  wb_q_t  q;
  wb_q_t  d;

  logic                  ready;
  logic                  fire;
  logic                  ebreak_pend;
  logic [DATA_WIDTH-1:0] ld_data;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [63:0]           instret_q;

  // Shift the doubleword down to the addressed byte, then size/extend.
  function automatic logic [DATA_WIDTH-1:0] load_ext(
    input logic [DATA_WIDTH-1:0] rdata,
    input logic [2:0]            off,
    input logic [2:0]            f3
  );
    logic [DATA_WIDTH-1:0] sh;
    logic [DATA_WIDTH-1:0] r;
    sh = rdata >> {off, 3'b000};
    r  = '0;
    case (f3)
      3'd0: r = {{(DATA_WIDTH-8){sh[7]}}, sh[7:0]};
      3'd1: r = {{(DATA_WIDTH-16){sh[15]}}, sh[15:0]};
      3'd2: r = {{(DATA_WIDTH-32){sh[31]}}, sh[31:0]};
      3'd3: r = sh;
      3'd4: r = {{(DATA_WIDTH-8){1'b0}}, sh[7:0]};
      3'd5: r = {{(DATA_WIDTH-16){1'b0}}, sh[15:0]};
      3'd6: r = {{(DATA_WIDTH-32){1'b0}}, sh[31:0]};
      default: r = '0;
    endcase
    return r;
  endfunction

  assign ebreak_pend = q.valid && q.ebreak;
  assign fire        = in_valid && ready;

  // Write data selection at capture time.
  always_comb begin
    ld_data = load_ext(in_mem_rdata, in_alu_result[2:0], in_funct3);
    wr_data = in_is_load ? ld_data : in_alu_result;
  end

  // Next pipeline-register contents; empty unless a handshake happens.
  always_comb begin
    d = '0;
    if (fire) begin
      d.valid  = 1'b1;
      d.ebreak = in_is_ebreak;
      d.wen    = in_wen && !in_is_ebreak;
      d.rd     = in_rd;
      d.pc     = in_pc;
      d.data   = wr_data;
    end
  end

  // Pipeline register: each entry lives one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= '0;
    else     q <= d;
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // FSM next state and ready decode.
  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    unique case (state_q)
      RUN: begin
        ready = !stall && !ebreak_pend;
        if (ebreak_pend) state_d = HALT;
      end
      HALT: begin
        state_d = HALT;
        ready   = 1'b0;
      end
      default: begin
        state_d = RUN;
        ready   = 1'b0;
      end
    endcase
  end

  // Retired-instruction counter, wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          instret_q <= '0;
    else if (q.valid) instret_q <= instret_q + 64'd1;
  end

  // Register-file, forwarding and commit outputs.
  always_comb begin
    in_ready  = ready;
    rf_wen    = q.valid && q.wen && (q.rd != '0);
    rf_rd     = q.rd;
    rf_wdata  = q.data;
    fwd_valid = rf_wen;
    fwd_rd    = q.rd;
    fwd_data  = q.data;
    commit    = q.valid;
    commit_pc = q.pc;
    instret   = instret_q;
    halted    = (state_q == HALT);
  end

endmodule

// File: tb/tb_wb_stage.sv
// Directed testbench for wb_stage.
// Inputs are driven and outputs checked on the falling clock edge.
module tb_wb_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_pc;
  logic [4:0]  in_rd;
  logic        in_wen;
  logic        in_is_load;
  logic [2:0]  in_funct3;
  logic [63:0] in_alu_result;
  logic [63:0] in_mem_rdata;
  logic        in_is_ebreak;
  logic        stall;
  logic        rf_wen;
  logic [4:0]  rf_rd;
  logic [63:0] rf_wdata;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [63:0] fwd_data;
  logic        commit;
  logic [63:0] commit_pc;
  logic [63:0] instret;
  logic        halted;

  int n_chk;
  int n_fail;

  wb_stage dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_pc        (in_pc),
    .in_rd        (in_rd),
    .in_wen       (in_wen),
    .in_is_load   (in_is_load),
    .in_funct3    (in_funct3),
    .in_alu_result(in_alu_result),
    .in_mem_rdata (in_mem_rdata),
    .in_is_ebreak (in_is_ebreak),
    .stall        (stall),
    .rf_wen       (rf_wen),
    .rf_rd        (rf_rd),
    .rf_wdata     (rf_wdata),
    .fwd_valid    (fwd_valid),
    .fwd_rd       (fwd_rd),
    .fwd_data     (fwd_data),
    .commit       (commit),
    .commit_pc    (commit_pc),
    .instret      (instret),
    .halted       (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one instruction for a single cycle, then withdraw it.
  task automatic issue(input logic [63:0] pc, input logic [4:0] rd,
                       input logic wen, input logic ld,
                       input logic [2:0] f3, input logic [63:0] alu,
                       input logic [63:0] mem, input logic eb);
    in_valid      = 1'b1;
    in_pc         = pc;
    in_rd         = rd;
    in_wen        = wen;
    in_is_load    = ld;
    in_funct3     = f3;
    in_alu_result = alu;
    in_mem_rdata  = mem;
    in_is_ebreak  = eb;
    @(negedge clk);
    in_valid      = 1'b0;
    in_is_ebreak  = 1'b0;
  endtask

  logic [2:0]  ld_f3  [5];
  logic [63:0] ld_adr [5];
  logic [63:0] ld_exp [5];
  logic [63:0] mem_v;
  logic        exp_v;
  logic [63:0] exp_pc;
  logic [63:0] exp_d;
  logic        exp_rdy;
  int          k;

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    in_pc = '0;
    in_rd = '0;
    in_wen = 1'b0;
    in_is_load = 1'b0;
    in_funct3 = '0;
    in_alu_result = '0;
    in_mem_rdata = '0;
    in_is_ebreak = 1'b0;
    stall = 1'b0;
    mem_v = 64'h8877_6655_4433_2211;
    ld_f3[0] = 3'd0; ld_adr[0] = 64'h1007; ld_exp[0] = 64'hFFFF_FFFF_FFFF_FF88;
    ld_f3[1] = 3'd5; ld_adr[1] = 64'h1002; ld_exp[1] = 64'h0000_0000_0000_4433;
    ld_f3[2] = 3'd2; ld_adr[2] = 64'h1004; ld_exp[2] = 64'hFFFF_FFFF_8877_6655;
    ld_f3[3] = 3'd3; ld_adr[3] = 64'h1000; ld_exp[3] = 64'h8877_6655_4433_2211;
    ld_f3[4] = 3'd2; ld_adr[4] = 64'h1006; ld_exp[4] = 64'h0000_0000_0000_8877;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_rf_wen", 64'(rf_wen), 64'd0);
    check("rst_rf_rd", 64'(rf_rd), 64'd0);
    check("rst_rf_wdata", rf_wdata, 64'd0);
    check("rst_fwd_valid", 64'(fwd_valid), 64'd0);
    check("rst_commit", 64'(commit), 64'd0);
    check("rst_commit_pc", commit_pc, 64'd0);
    check("rst_instret", instret, 64'd0);
    check("rst_halted", 64'(halted), 64'd0);
    @(negedge clk);

    // ALU result writeback
    issue(64'h8000_0000, 5'd5, 1'b1, 1'b0, 3'd0, 64'h1234, 64'd0, 1'b0);
    check("alu_rf_wen", 64'(rf_wen), 64'd1);
    check("alu_rf_rd", 64'(rf_rd), 64'd5);
    check("alu_rf_wdata", rf_wdata, 64'h1234);
    check("alu_commit", 64'(commit), 64'd1);
    check("alu_commit_pc", commit_pc, 64'h8000_0000);
    check("alu_fwd_valid", 64'(fwd_valid), 64'd1);
    check("alu_fwd_rd", 64'(fwd_rd), 64'd5);
    check("alu_fwd_data", fwd_data, 64'h1234);
    @(negedge clk);
    check("alu_instret", instret, 64'd1);
    check("alu_commit_drop", 64'(commit), 64'd0);

    // Load extraction
    for (int i = 0; i < 5; i++) begin
      issue(64'h8000_0010 + 64'(4 * i), 5'd10, 1'b1, 1'b1, ld_f3[i],
            ld_adr[i], mem_v, 1'b0);
      check($sformatf("load%0d_wdata", i), rf_wdata, ld_exp[i]);
      check($sformatf("load%0d_wen", i), 64'(rf_wen), 64'd1);
    end
    @(negedge clk);
    check("load_instret", instret, 64'd6);

    // x0 is never written but still retires
    issue(64'h8000_0040, 5'd0, 1'b1, 1'b0, 3'd0, 64'hDEAD, 64'd0, 1'b0);
    check("x0_rf_wen", 64'(rf_wen), 64'd0);
    check("x0_fwd_valid", 64'(fwd_valid), 64'd0);
    check("x0_commit", 64'(commit), 64'd1);
    @(negedge clk);
    check("x0_instret", instret, 64'd7);

    // Back-to-back with a stall on the third cycle
    exp_v = 1'b0;
    exp_pc = '0;
    exp_d = '0;
    k = 0;
    for (int cyc = 0; cyc < 7; cyc++) begin
      check($sformatf("b2b%0d_commit", cyc), 64'(commit), 64'(exp_v));
      if (exp_v) begin
        check($sformatf("b2b%0d_pc", cyc), commit_pc, exp_pc);
        check($sformatf("b2b%0d_wdata", cyc), rf_wdata, exp_d);
      end
      if (k < 4) begin
        in_valid      = 1'b1;
        in_pc         = 64'h8000_0100 + 64'(4 * k);
        in_rd         = 5'd3;
        in_wen        = 1'b1;
        in_is_load    = 1'b0;
        in_alu_result = 64'h100 + 64'(k);
        stall         = (cyc == 2);
        exp_rdy       = (cyc != 2);
        #1;
        check($sformatf("b2b%0d_ready", cyc), 64'(in_ready), 64'(exp_rdy));
        exp_v  = exp_rdy;
        exp_pc = in_pc;
        exp_d  = in_alu_result;
        if (exp_rdy) k++;
      end else begin
        in_valid = 1'b0;
        stall    = 1'b0;
        exp_v    = 1'b0;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    stall = 1'b0;
    check("b2b_instret", instret, 64'd11);

    // Ebreak halts and blocks younger instructions
    in_valid      = 1'b1;
    in_pc         = 64'h8000_0200;
    in_rd         = 5'd7;
    in_wen        = 1'b1;
    in_is_load    = 1'b0;
    in_alu_result = 64'h77;
    in_is_ebreak  = 1'b1;
    @(negedge clk);
    in_is_ebreak  = 1'b0;
    in_pc         = 64'h8000_0204;
    check("ebrk_commit", 64'(commit), 64'd1);
    check("ebrk_commit_pc", commit_pc, 64'h8000_0200);
    check("ebrk_rf_wen", 64'(rf_wen), 64'd0);
    check("ebrk_ready_n1", 64'(in_ready), 64'd0);
    check("ebrk_halted_n1", 64'(halted), 64'd0);
    @(negedge clk);
    check("ebrk_halted", 64'(halted), 64'd1);
    check("ebrk_instret", instret, 64'd12);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("halt%0d_ready", i), 64'(in_ready), 64'd0);
      check($sformatf("halt%0d_commit", i), 64'(commit), 64'd0);
      @(negedge clk);
    end
    check("halt_instret", instret, 64'd12);
    in_valid = 1'b0;

    // Reset leaves HALT
    rst = 1'b1;
    #1;
    check("rst2_halted", 64'(halted), 64'd0);
    check("rst2_instret", instret, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst2_ready", 64'(in_ready), 64'd1);
    @(negedge clk);

    // Async reset between edges drops the pending entry
    in_valid      = 1'b1;
    in_pc         = 64'h8000_0300;
    in_rd         = 5'd9;
    in_wen        = 1'b1;
    in_alu_result = 64'h99;
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    check("arst_pre_commit", 64'(commit), 64'd1);
    check("arst_pre_wen", 64'(rf_wen), 64'd1);
    rst = 1'b1;
    #1;
    check("arst_commit", 64'(commit), 64'd0);
    check("arst_rf_wen", 64'(rf_wen), 64'd0);
    check("arst_fwd_valid", 64'(fwd_valid), 64'd0);
    check("arst_instret", instret, 64'd0);
    check("arst_halted", 64'(halted), 64'd0);
    #1;
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("arst_post_instret", instret, 64'd0);
    check("arst_post_ready", 64'(in_ready), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage of the NPC core: accepts one completed instruction per cycle from the memory-access stage over a valid/ready handshake. It holds the instruction in a one-entry pipeline register, extracts and sign/zero-extends load data, and drives the register-file write port (`wen`, `rd`, `wdata`) in the following cycle. It also publishes a forwarding tap for the decode stage, counts retired instructions, and halts the core on `ebreak`.

## Interface
- `DATA_WIDTH`, 64, register and datapath width
- `ADDR_WIDTH`, 5, register index width
- `clk` in 1, the single clock; all state updates on its rising edge
- `rst` in 1, reset; asynchronous, active-high
- `in_valid` in 1, upstream offers an instruction
- `in_ready` out 1, stage accepts this cycle
- `in_pc` in DATA_WIDTH, instruction PC (carried for commit)
- `in_rd` in ADDR_WIDTH, destination register
- `in_wen` in 1, instruction writes rd
- `in_is_load` in 1, result comes from memory
- `in_funct3` in 3, load size/sign: 0 lb, 1 lh, 2 lw, 3 ld, 4 lbu, 5 lhu, 6 lwu
- `in_alu_result` in DATA_WIDTH, ALU result; for loads, the effective address
- `in_mem_rdata` in DATA_WIDTH, 8-byte-aligned doubleword read from memory
- `in_is_ebreak` in 1, instruction is ebreak
- `stall` in 1, external hold; forces `in_ready` low
- `rf_wen` out 1, register-file write enable
- `rf_rd` out ADDR_WIDTH, register-file write index
- `rf_wdata` out DATA_WIDTH, register-file write data
- `fwd_valid` out 1, `fwd_rd`/`fwd_data` hold a pending write
- `fwd_rd` out ADDR_WIDTH, forwarding destination
- `fwd_data` out DATA_WIDTH, forwarding value
- `commit` out 1, one-cycle pulse per retired instruction
- `commit_pc` out DATA_WIDTH, PC of the retiring instruction
- `instret` out 64, retired-instruction count
- `halted` out 1, core halted by ebreak

## Operation
- State machine has two states:
  - RUN: reset state; normal operation.
  - HALT: terminal; entered at the edge that retires an ebreak; left only by `rst`.
- `in_ready` = (state==RUN) && !`stall` && !(`valid_q` && `ebreak_q`).
  - The ebreak entry blocks all younger instructions.
- Capture: on `in_valid && in_ready`, latch pc, rd, wen, ebreak and the final write data into the pipeline register, and set `valid_q`=1.
  - Otherwise `valid_q`=0 at the next edge; every entry lives exactly one cycle.
- Write data is computed at capture:
  - Non-load: `in_alu_result`.
  - Load: shift `in_mem_rdata` right by 8*`in_alu_result[2:0]`, zero-fill the vacated upper bytes, then extend per `in_funct3` (lb/lh/lw sign-extend from bit 7/15/31; lbu/lhu/lwu zero-extend; ld passes through).
  - Bytes needed beyond the doubleword read as zero; no trap.
  - funct3=7 on a load: write data is 0.
- `rf_wen` = `valid_q` && `wen_q` && (`rd_q`!=0); x0 is never written. `rf_rd`=`rd_q`, `rf_wdata`=`data_q`.
- `fwd_valid` = `rf_wen`; `fwd_rd`/`fwd_data` equal `rf_rd`/`rf_wdata`.
- `commit` = `valid_q`; `commit_pc` = `pc_q`. ebreak commits and counts, and performs no register write even if `in_wen`=1.
- `instret` increments by 1 at every edge where `commit`=1; it wraps modulo 2^64.

## Timing
- Reset values:
  - Outputs: `in_ready`=1 (if `stall`=0), `rf_wen`=0, `rf_rd`=0, `rf_wdata`=0, `fwd_valid`=0, `commit`=0, `commit_pc`=0, `instret`=0, `halted`=0.
  - Internal: state=RUN; all pipeline registers 0.
- Latency: handshake at edge N means `rf_*`/`commit` are valid during cycle N+1, and the register file writes at edge N+1.
- Throughput: one instruction per cycle while `stall`=0 and no ebreak is present; back-to-back writes to the same rd are applied in order.
- `stall` takes effect combinationally in the same cycle; an entry already captured still retires the next cycle.
- Ebreak captured at edge N: `in_ready`=0 during cycle N+1; state=HALT and `halted`=1 from edge N+1 onward; `in_ready` stays 0 thereafter.
- `rst` asserted mid-operation clears the pending entry immediately, with no write and no commit, and returns to RUN with `instret`=0.

## Test plan
- Reset then ALU op: rd=5, wen=1, alu_result=0x1234 accepted at edge 1 -> cycle 2 shows `rf_wen`=1, `rf_rd`=5, `rf_wdata`=0x1234, `commit`=1; `instret`=1 after edge 2.
- Loads with mem_rdata=0x8877_6655_4433_2211:
  - lb, addr[2:0]=7 -> wdata 0xFFFF_FFFF_FFFF_FF88.
  - lhu, addr=2 -> 0x4433.
  - lw, addr=4 -> 0xFFFF_FFFF_8877_6655.
  - ld, addr=0 -> unchanged.
  - lw, addr=6 -> 0x0000_8877.
- x0 write: rd=0, wen=1, data=0xDEAD -> `rf_wen`=0, `commit`=1, `instret`+1.
- Back-to-back with stall: 4 instructions issued with `stall` high on the 3rd cycle -> `in_ready` low that cycle; 4 commits in order; `instret`=4.
- Ebreak: ebreak at edge N followed by `in_valid` held high -> one commit, no write, `halted`=1 from N+1; `in_ready` stays 0 for 10+ cycles.
- Async reset: `rst` pulsed between edges while `valid_q`=1 -> `rf_wen` and `commit` drop immediately, `instret`=0, `halted`=0.
